// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory geometry and loader state encoding
package imem_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-to-word shift register with 2-bit byte counter
module word_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 32'd0;
    end else if (accept_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {data_i, shift_q[31:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Complete word including the byte being accepted now; meaningful when word_full_o is high.
  assign word_o      = {data_i, shift_q[31:8]};
  assign word_full_o = accept_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte stream into instruction memory while holding the core
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = imem_pkg::DEPTH,
  parameter int ADDR_W = imem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              asm_full;
  logic              start_legal;

  assign accept      = (state_q == RECV) && byte_valid;
  assign start_legal = (word_count != '0) && (word_count <= DEPTH_W);

  word_assembler u_word_assembler (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (asm_clear),
    .accept_i    (accept),
    .data_i      (byte_data),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    error_d   = 1'b0;
    asm_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            count_d   = word_count;
            idx_d     = '0;
            asm_clear = 1'b1;
            state_d   = RECV;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (asm_full) begin
          wr_addr_d = idx_q;
          wr_data_d = asm_word;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        // count_q >= 1 here, so the last index is at most DEPTH-1 and idx never wraps.
        if ({1'b0, idx_q} == (count_q - CNT_ONE)) begin
          state_d = DONE;
        end else begin
          idx_d     = idx_q + IDX_ONE;
          asm_clear = 1'b1;
          state_d   = RECV;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    byte_ready_d = (state_d == RECV);
    wr_en_d      = (state_d == WRITE);
    core_hold_d  = (state_d == RECV) || (state_d == WRITE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      core_hold_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_hold;
  logic              done;
  logic              error;

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per strobe seen on the DUT outputs.
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (!reset && (wr_en || done || error)) begin
      chk("one_strobe", $countones({wr_en, done, error}), 1);
      if (wr_en) begin
        wr_seen++;
        last_addr = wr_addr;
        chk("hold_in_write", core_hold, 1);
      end
      if (done)  chk("hold_at_done", core_hold, 0);
      if (error) chk("hold_at_error", core_hold, 0);
      kind = wr_en ? K_WR : (done ? K_DONE : K_ERR);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event kind=%0d addr=%0d data=%h required=none", kind, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == K_WR && e.kind == K_WR) begin
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr[ADDR_W-1:0];
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int n);
    start      = 1'b1;
    word_count = n[ADDR_W:0];
    tick();
    start      = 1'b0;
    word_count = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  logic [31:0] quad [4];
  int          base;

  initial begin
    quad[0] = 32'h12345678;
    quad[1] = 32'h9ABCDEF0;
    quad[2] = 32'h0000FFFF;
    quad[3] = 32'hA5A5005A;

    reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_core_hold", core_hold, 0);
    chk("rst_done_error", {done, error}, 0);

    // Two-word program, bytes back-to-back.
    push(K_WR, 0, 32'h00500013);
    push(K_WR, 1, 32'h00100093);
    push(K_DONE, 0, 0);
    do_start(2);
    chk("hold_after_start", core_hold, 1);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    drain();

    // Illegal counts: error pulse only.
    push(K_ERR, 0, 0);
    do_start(0);
    drain();
    chk("hold_after_err0", core_hold, 0);
    push(K_ERR, 0, 0);
    do_start(65);
    drain();
    chk("hold_after_err65", core_hold, 0);

    // Four words gapless, then the same words with random gaps.
    for (int pass = 0; pass < 2; pass++) begin
      base = wr_seen;
      for (int i = 0; i < 4; i++) push(K_WR, i, quad[i]);
      push(K_DONE, 0, 0);
      do_start(4);
      for (int i = 0; i < 4; i++) send_word(quad[i], pass * 5);
      drain();
      chk("four_writes", wr_seen - base, 4);
    end

    // Full-depth load.
    base = wr_seen;
    for (int i = 0; i < 64; i++) push(K_WR, i, 32'hC0DE0000 | i);
    push(K_DONE, 0, 0);
    do_start(64);
    for (int i = 0; i < 64; i++) send_word(32'hC0DE0000 | i, 0);
    drain();
    chk("full_writes", wr_seen - base, 64);
    chk("full_last_addr", last_addr, 63);

    // Reset mid-word 1, with start/byte_valid asserted on the reset edge.
    push(K_WR, 0, 32'h11223344);
    do_start(2);
    send_word(32'h11223344, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
    reset = 1'b1; start = 1'b1; word_count = 7'd1; byte_valid = 1'b1; byte_data = 8'hDD;
    tick();
    reset = 1'b0; start = 1'b0; word_count = '0; byte_valid = 1'b0;
    chk("mid_rst_byte_ready", byte_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_hold", core_hold, 0);
    chk("mid_rst_done_error", {done, error}, 0);
    drain();
    chk("rst_ignores_start", core_hold, 0);
    push(K_WR, 0, 32'hDEADBEEF);
    push(K_DONE, 0, 0);
    do_start(1);
    send_word(32'hDEADBEEF, 0);
    drain();

    // start pulsed during RECV must not disturb count or index.
    base = wr_seen;
    push(K_WR, 0, 32'h0BADF00D);
    push(K_WR, 1, 32'h76543210);
    push(K_DONE, 0, 0);
    do_start(2);
    send_byte(8'h0D, 0); send_byte(8'hF0, 0);
    do_start(5);
    send_byte(8'hAD, 0); send_byte(8'h0B, 0);
    send_word(32'h76543210, 0);
    drain();
    chk("recv_start_writes", wr_seen - base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of 32-bit instruction memory words.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning word-address width (log2 DEPTH).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 The block SHALL have port word_count  input  ADDR_W+1  number of words to load, sampled with start.
REQ-007 The block SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-008 The block SHALL have port byte_data  input  8  program byte stream, little-endian per word.
REQ-009 The block SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 The block SHALL have port wr_en  output  1  instruction memory write strobe.
REQ-011 The block SHALL have port wr_addr  output  ADDR_W  word index being written.
REQ-012 The block SHALL have port wr_data  output  32  assembled instruction word.
REQ-013 The block SHALL have port core_hold  output  1  holds the core in reset while loading.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-015 The block SHALL have port error  output  1  one-cycle pulse on an illegal start.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-017 In IDLE, start with 1 <= word_count <= DEPTH SHALL latch word_count, clear the word index and byte counter, and move to RECV next cycle.
REQ-018 In IDLE, start with word_count = 0 or > DEPTH SHALL pulse error the next cycle and remain in IDLE.
REQ-019 start SHALL be ignored in RECV, WRITE and DONE.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte is accepted on a cycle with byte_valid && byte_ready.
REQ-021 Accepted byte n (0..3) of a word SHALL be placed in wr_data bits [8n+7:8n].
REQ-022 A cycle without byte_valid in RECV SHALL hold all state; gaps of any length are legal.
REQ-023 Acceptance of byte 3 SHALL move the FSM to WRITE, so wr_en is high exactly on the cycle after the fourth byte is accepted.
REQ-024 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr = current word index and wr_data = the assembled word.
REQ-025 From WRITE, the FSM SHALL go to DONE if word index = latched count-1; otherwise it SHALL increment the index, clear the byte counter and return to RECV.
REQ-026 The word index SHALL never wrap: the maximum index written is DEPTH-1.
REQ-027 core_hold SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE.
REQ-028 In DONE, done SHALL be 1 for one cycle, followed by an unconditional return to IDLE.
REQ-029 wr_en, done and error SHALL never be high simultaneously.

Reset
REQ-030 When reset is high at a clock edge, the FSM SHALL go to IDLE and byte_ready, wr_en, core_hold, done and error SHALL be 0.
REQ-031 Reset SHALL force wr_addr and wr_data to 0 and clear the word index, byte counter and latched count.
REQ-032 Reset during RECV or WRITE SHALL discard any partial word, issue no further wr_en, and leave already-written words untouched.
REQ-033 Reset SHALL take priority over start and byte_valid in the same cycle.

Structure
REQ-034 DEPTH, ADDR_W and the state encoding SHALL be defined in a shared package, imem_pkg, which is used by the loader and the instruction memory.
REQ-035 Byte-to-word assembly, covering the shift register and 2-bit byte counter, SHALL be a sub-module named word_assembler, with clear and byte-accept inputs and a word_full output.
REQ-036 The FSM, word index and output registers SHALL reside in imem_loader; all outputs SHALL be registered.

Verification
REQ-037 The bench SHALL drive start with word_count=2 and bytes 13,00,50,00,93,00,10,00 back-to-back, and check wr_en at addr 0 with data 0x00500013, wr_en at addr 1 with data 0x00100093, then one done pulse.
REQ-038 The bench SHALL drive start with word_count=0 and with word_count=65, and check a single error pulse each time, core_hold=0 and no wr_en.
REQ-039 The bench SHALL insert random byte_valid gaps of 0-5 cycles for word_count=4, and check the words are identical to the gapless run and that wr_en occurs exactly 4 times.
REQ-040 The bench SHALL load word_count=64, and check that the final wr_addr is 63, no write occurs to address 0 after index 0, and done follows.
REQ-041 The bench SHALL assert reset after byte 2 of word 1, and check there is no wr_en for word 1, that the next cycle is IDLE with all outputs 0, and that a new start loads from address 0.
REQ-042 The bench SHALL pulse start while in RECV, and check the latched count and word index are unchanged.
